// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared definitions for the gate BIST checker.
//   - gate_sel encodings (GATE_AND .. GATE_NOT)
//   - FSM state encoding
//   - exp_out(): expected output of a gate over the low n bits of a vector
package gate_bist_pkg;

   // Widest vector the reference function handles.
   localparam int MAX_IN = 8;

   localparam logic [2:0] GATE_AND  = 3'd0;
   localparam logic [2:0] GATE_OR   = 3'd1;
   localparam logic [2:0] GATE_XOR  = 3'd2;
   localparam logic [2:0] GATE_NAND = 3'd3;
   localparam logic [2:0] GATE_NOR  = 3'd4;
   localparam logic [2:0] GATE_XNOR = 3'd5;
   localparam logic [2:0] GATE_BUF  = 3'd6;
   localparam logic [2:0] GATE_NOT  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_APPLY  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // Reductions are taken over bits [n-1:0] only; upper bits are ignored so
   // that zero padding does not corrupt the AND reduction.
   function automatic logic exp_out(input logic [2:0]        sel,
                                    input logic [MAX_IN-1:0] vec,
                                    input int                n);
      logic r_and;
      logic r_or;
      logic r_xor;
      logic r;
      r_and = 1'b1;
      r_or  = 1'b0;
      r_xor = 1'b0;
      for (int i = 0; i < MAX_IN; i++) begin
         if (i < n) begin
            r_and = r_and & vec[i];
            r_or  = r_or  | vec[i];
            r_xor = r_xor ^ vec[i];
         end
      end
      case (sel)
         GATE_AND:  r = r_and;
         GATE_OR:   r = r_or;
         GATE_XOR:  r = r_xor;
         GATE_NAND: r = ~r_and;
         GATE_NOR:  r = ~r_or;
         GATE_XNOR: r = ~r_xor;
         GATE_BUF:  r = vec[0];
         default:   r = ~vec[0];
      endcase
      return r;
   endfunction

endpackage

// File: rtl/gate_bist_checker_ref.sv
// gate_ref_model: combinational truth-table reference for the basic gates.
//   sel  in  3       gate type (gate_bist_pkg encodings)
//   vec  in  NUM_IN  input vector, MSB is the first gate input
//   exp  out 1       expected gate output
module gate_ref_model #(
   parameter int NUM_IN = 2
) (
   input  logic [2:0]        sel,
   input  logic [NUM_IN-1:0] vec,
   output logic              exp
);
   import gate_bist_pkg::*;

   logic [MAX_IN-1:0] vec_ext;

   always_comb begin
      vec_ext              = '0;
      vec_ext[NUM_IN-1:0]  = vec;
      exp                  = exp_out(sel, vec_ext, NUM_IN);
   end

endmodule

// File: rtl/gate_bist_checker.sv
// gate_bist_checker: on-chip response analyser for a combinational gate.
// Sweeps every input vector into the gate under test, holds each for SETTLE
// cycles, samples gut_y for one cycle and compares it against the expected
// truth table of the latched gate type.
//   clk, rst     clock, async active-high reset
//   start        begin sweep (accepted only in IDLE or DONE)
//   gate_sel     expected gate function, latched at start
//   vec_out      stimulus to the GUT
//   gut_y        GUT output, used only in SAMPLE
//   busy/done    sweep running / sweep complete (held)
//   pass         done with zero mismatches
//   err_cnt      saturating mismatch count
//   ff_valid/ff_vec/ff_y  first-failure record
module gate_bist_checker #(
   parameter int NUM_IN = 2,
   parameter int SETTLE = 2,
   parameter int ERR_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        gate_sel,
   output logic [NUM_IN-1:0] vec_out,
   input  logic              gut_y,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_cnt,
   output logic              ff_valid,
   output logic [NUM_IN-1:0] ff_vec,
   output logic              ff_y
);
   import gate_bist_pkg::*;

   localparam int               CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

   state_e              state_q,    state_d;
   logic [2:0]          sel_q,      sel_d;
   logic [CNT_W-1:0]    cnt_q,      cnt_d;
   logic [NUM_IN-1:0]   vec_q,      vec_d;
   logic [ERR_W-1:0]    err_q,      err_d;
   logic                ff_valid_q, ff_valid_d;
   logic [NUM_IN-1:0]   ff_vec_q,   ff_vec_d;
   logic                ff_y_q,     ff_y_d;
   logic                exp_y;

   gate_ref_model #(.NUM_IN(NUM_IN)) u_ref (
      .sel (sel_q),
      .vec (vec_q),
      .exp (exp_y)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         sel_q      <= '0;
         cnt_q      <= '0;
         vec_q      <= '0;
         err_q      <= '0;
         ff_valid_q <= 1'b0;
         ff_vec_q   <= '0;
         ff_y_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         cnt_q      <= cnt_d;
         vec_q      <= vec_d;
         err_q      <= err_d;
         ff_valid_q <= ff_valid_d;
         ff_vec_q   <= ff_vec_d;
         ff_y_q     <= ff_y_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      cnt_d      = cnt_q;
      vec_d      = vec_q;
      err_d      = err_q;
      ff_valid_d = ff_valid_q;
      ff_vec_d   = ff_vec_q;
      ff_y_d     = ff_y_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               sel_d      = gate_sel;
               cnt_d      = '0;
               vec_d      = '0;
               err_d      = '0;
               ff_valid_d = 1'b0;
               ff_vec_d   = '0;
               ff_y_d     = 1'b0;
               state_d    = ST_APPLY;
            end
         end
         ST_APPLY: begin
            // cnt_q counts completed APPLY cycles; the SETTLE-th moves on.
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_SAMPLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_SAMPLE: begin
            if (gut_y != exp_y) begin
               if (err_q != '1) err_d = err_q + 1'b1;
               if (!ff_valid_q) begin
                  ff_valid_d = 1'b1;
                  ff_vec_d   = vec_q;
                  ff_y_d     = gut_y;
               end
            end
            if (vec_q == '1) begin
               state_d = ST_DONE;
            end else begin
               vec_d   = vec_q + 1'b1;
               state_d = ST_APPLY;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign vec_out  = vec_q;
   assign busy     = (state_q == ST_APPLY) || (state_q == ST_SAMPLE);
   assign done     = (state_q == ST_DONE);
   assign pass     = done && (err_q == '0);
   assign err_cnt  = err_q;
   assign ff_valid = ff_valid_q;
   assign ff_vec   = ff_vec_q;
   assign ff_y     = ff_y_q;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Directed bench for gate_bist_checker. Two instances share stimulus:
// dut (ERR_W=4) and dut1 (ERR_W=1, saturation check). Both GUTs are OR
// gates; dut's GUT can be forced stuck-at-0.
module tb_gate_bist_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [2:0] gate_sel;
   logic       gut_stuck;

   logic [1:0] vec_out,  ff_vec,  vec_out1, ff_vec1;
   logic [3:0] err_cnt;
   logic [0:0] err_cnt1;
   logic       busy, done, pass, ff_valid, ff_y, gut_y;
   logic       busy1, done1, pass1, ff_valid1, ff_y1, gut_y1;

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   always #5 clk = ~clk;

   assign gut_y  = gut_stuck ? 1'b0 : |vec_out;
   assign gut_y1 = |vec_out1;

   gate_bist_checker #(.NUM_IN(2), .SETTLE(2), .ERR_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel),
      .vec_out(vec_out), .gut_y(gut_y), .busy(busy), .done(done),
      .pass(pass), .err_cnt(err_cnt), .ff_valid(ff_valid),
      .ff_vec(ff_vec), .ff_y(ff_y)
   );

   gate_bist_checker #(.NUM_IN(2), .SETTLE(2), .ERR_W(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel),
      .vec_out(vec_out1), .gut_y(gut_y1), .busy(busy1), .done(done1),
      .pass(pass1), .err_cnt(err_cnt1), .ff_valid(ff_valid1),
      .ff_vec(ff_vec1), .ff_y(ff_y1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_res(input string tag, input int err, input bit ffv,
                          input int ffvec, input bit ffy, input bit pss);
      chk({tag, ".done"},     32'(done),     32'd1);
      chk({tag, ".busy"},     32'(busy),     32'd0);
      chk({tag, ".vec_last"}, 32'(vec_out),  32'd3);
      chk({tag, ".err"},      32'(err_cnt),  32'(err));
      chk({tag, ".ffv"},      32'(ff_valid), 32'(ffv));
      chk({tag, ".ffvec"},    32'(ff_vec),   32'(ffvec));
      chk({tag, ".ffy"},      32'(ff_y),     32'(ffy));
      chk({tag, ".pass"},     32'(pass),     32'(pss));
   endtask

   // Start pulse then step 12 cycles: vector k/3 held 3 cycles each.
   // With noisy=1, start is re-pulsed and gate_sel wiggled while busy.
   task automatic run_sweep(input string tag, input logic [2:0] sel, input bit noisy);
      gate_sel = sel;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      for (int k = 0; k < 12; k++) begin
         chk($sformatf("%s.vec%0d", tag, k),  32'(vec_out), 32'(k / 3));
         chk($sformatf("%s.busy%0d", tag, k), 32'(busy),    32'd1);
         chk($sformatf("%s.done%0d", tag, k), 32'(done),    32'd0);
         if (noisy) begin
            gate_sel = 3'(k);
            start    = (k == 4 || k == 8);
         end
         tick();
      end
      start = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      gate_sel  = 3'd0;
      gut_stuck = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.busy",  32'(busy),     32'd0);
      chk("rst.done",  32'(done),     32'd0);
      chk("rst.pass",  32'(pass),     32'd0);
      chk("rst.vec",   32'(vec_out),  32'd0);
      chk("rst.err",   32'(err_cnt),  32'd0);
      chk("rst.ffv",   32'(ff_valid), 32'd0);
      rst = 1'b0;
      tick();
      chk("idle.busy", 32'(busy),     32'd0);

      // 1: OR gut, OR expected -> clean pass
      run_sweep("s1", 3'd1, 1'b0);
      chk_res("s1", 0, 1'b0, 0, 1'b0, 1'b1);

      // 2: stuck-at-0 -> vectors 1,2,3 fail
      gut_stuck = 1'b1;
      run_sweep("s2", 3'd1, 1'b0);
      chk_res("s2", 3, 1'b1, 1, 1'b0, 1'b0);
      gut_stuck = 1'b0;

      // start from DONE clears the previous result
      gate_sel = 3'd1;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      chk("restart.err",  32'(err_cnt),  32'd0);
      chk("restart.ffv",  32'(ff_valid), 32'd0);
      chk("restart.done", 32'(done),     32'd0);
      chk("restart.busy", 32'(busy),     32'd1);
      repeat (12) tick();
      chk_res("restart", 0, 1'b0, 0, 1'b0, 1'b1);

      // 3: OR gut vs AND expected -> vectors 1,2 fail
      run_sweep("s3", 3'd0, 1'b0);
      chk_res("s3", 2, 1'b1, 1, 1'b1, 1'b0);

      // 4: OR gut vs NOR expected -> all 4 fail; ERR_W=1 saturates at 1
      run_sweep("s4", 3'd4, 1'b0);
      chk_res("s4", 4, 1'b1, 0, 1'b0, 1'b0);
      chk("s4.err1",   32'(err_cnt1),  32'd1);
      chk("s4.ffv1",   32'(ff_valid1), 32'd1);
      chk("s4.ffvec1", 32'(ff_vec1),   32'd0);
      chk("s4.ffy1",   32'(ff_y1),     32'd0);
      chk("s4.done1",  32'(done1),     32'd1);
      chk("s4.pass1",  32'(pass1),     32'd0);

      // 5: async reset in APPLY of vector 2, checked before any edge
      gate_sel = 3'd0;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      repeat (7) tick();
      chk("s5.pre_vec", 32'(vec_out), 32'd2);
      #1 rst = 1'b1;
      #1;
      chk("s5.busy", 32'(busy),     32'd0);
      chk("s5.vec",  32'(vec_out),  32'd0);
      chk("s5.err",  32'(err_cnt),  32'd0);
      chk("s5.ffv",  32'(ff_valid), 32'd0);
      chk("s5.ffvec",32'(ff_vec),   32'd0);
      chk("s5.ffy",  32'(ff_y),     32'd0);
      chk("s5.done", 32'(done),     32'd0);
      rst = 1'b0;
      tick();
      chk("s5.idle", 32'(busy), 32'd0);
      run_sweep("s5b", 3'd1, 1'b0);
      chk_res("s5b", 0, 1'b0, 0, 1'b0, 1'b1);

      // 6: start pulses and gate_sel changes while busy are ignored
      run_sweep("s6", 3'd1, 1'b1);
      chk_res("s6", 0, 1'b0, 0, 1'b0, 1'b1);

      // start held high: one sweep, next begins on first DONE edge
      gate_sel = 3'd1;
      start    = 1'b1;
      tick();
      repeat (12) tick();
      chk("hold.done", 32'(done), 32'd1);
      chk("hold.pass", 32'(pass), 32'd1);
      tick();
      chk("hold.busy", 32'(busy),    32'd1);
      chk("hold.vec",  32'(vec_out), 32'd0);
      start = 1'b0;
      repeat (12) tick();
      chk_res("hold", 0, 1'b0, 0, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
